pic_call_stack: RTL and testbench

Parametrised hardware return-address stack for the PIC16-class multi-cycle core. It replaces the fixed 16×11 inline stack with a standalone block that adds:

- configurable width and depth;
- wrap or saturate overflow policy;
- sticky overflow/underflow flags;
- simultaneous push+pop (TOS replace) and a debug TOS write port.

---
 rtl/pic_pkg.sv | 12 +
 rtl/pic_stack_ram.sv | 25 ++
 rtl/pic_call_stack.sv | 144 ++++++++++++++
 tb/tb_pic_call_stack.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pic_pkg.sv
// Shared PIC16-class core definitions: PC width, default stack depth, stack overflow modes.
package pic_pkg;

  localparam int PC_W        = 11;
  localparam int STACK_DEPTH = 16;

  typedef logic [PC_W-1:0] pc_t;

  localparam int STK_WRAP = 0;
  localparam int STK_SAT  = 1;

endpackage

// File: rtl/pic_stack_ram.sv
// DEPTH x WIDTH register file for the call stack: one synchronous write port, one async read port, no reset.
module pic_stack_ram #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 16,
  parameter int PW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [PW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [PW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = r_mem[rd_addr];

endmodule

// File: rtl/pic_call_stack.sv
// Parametrised return-address stack with wrap/saturate overflow policy and sticky flags.
// Optional macro PIC_STACK_OVF_RESET_EN adds the one-cycle rst_req output.
module pic_call_stack
  import pic_pkg::*;
#(
  parameter int WIDTH    = PC_W,
  parameter int DEPTH    = STACK_DEPTH,
  parameter int SATURATE = STK_WRAP,
  parameter int PW       = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  input  logic             tos_wr,
  input  logic [WIDTH-1:0] tos_wdata,
  input  logic             clr_flags,
  output logic [WIDTH-1:0] tos,
  output logic [PW-1:0]    ptr,
  output logic [PW:0]      level,
  output logic             empty,
  output logic             full,
  output logic             stkovf,
`ifdef PIC_STACK_OVF_RESET_EN
  output logic             stkunf,
  output logic             rst_req
`else
  output logic             stkunf
`endif
);

  localparam logic [PW:0] LVL_FULL = (PW+1)'(DEPTH);

  logic [PW-1:0]    r_ptr;
  logic [PW:0]      r_level;
  logic             r_ovf;
  logic             r_unf;

  logic             w_empty;
  logic             w_full;
  logic             w_wrEn;
  logic [PW-1:0]    w_wrAddr;
  logic [WIDTH-1:0] w_wrData;
  logic [WIDTH-1:0] w_rdData;
  logic [PW-1:0]    w_ptrNext;
  logic [PW:0]      w_levelNext;
  logic             w_setOvf;
  logic             w_setUnf;

  assign w_empty = (r_level == '0);
  assign w_full  = (r_level == LVL_FULL);

  // tos_wr masks push/pop; push+pop on a non-empty stack replaces TOS in place.
  always_comb begin
    w_wrEn      = 1'b0;
    w_wrAddr    = r_ptr;
    w_wrData    = push_data;
    w_ptrNext   = r_ptr;
    w_levelNext = r_level;
    w_setOvf    = 1'b0;
    w_setUnf    = 1'b0;
    if (tos_wr) begin
      w_wrEn   = !w_empty;
      w_wrData = tos_wdata;
    end else if (push && pop && !w_empty) begin
      w_wrEn = 1'b1;
    end else if (push) begin
      if (w_full) begin
        w_setOvf = 1'b1;
        if (SATURATE == STK_WRAP) begin
          w_wrEn    = 1'b1;
          w_wrAddr  = r_ptr + PW'(1);
          w_ptrNext = r_ptr + PW'(1);
        end
      end else begin
        w_wrEn      = 1'b1;
        w_wrAddr    = r_ptr + PW'(1);
        w_ptrNext   = r_ptr + PW'(1);
        w_levelNext = r_level + (PW+1)'(1);
      end
    end else if (pop) begin
      if (w_empty) begin
        w_setUnf = 1'b1;
        if (SATURATE == STK_WRAP) begin
          w_ptrNext = r_ptr - PW'(1);
        end
      end else begin
        w_ptrNext   = r_ptr - PW'(1);
        w_levelNext = r_level - (PW+1)'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr   <= PW'(DEPTH - 1);
      r_level <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      r_ptr   <= w_ptrNext;
      r_level <= w_levelNext;
      r_ovf   <= w_setOvf | (r_ovf & ~clr_flags);
      r_unf   <= w_setUnf | (r_unf & ~clr_flags);
    end
  end

`ifdef PIC_STACK_OVF_RESET_EN
  logic r_rstReq;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rstReq <= 1'b0;
    end else begin
      r_rstReq <= w_setOvf | w_setUnf;
    end
  end

  assign rst_req = r_rstReq;
`endif

  pic_stack_ram #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .PW   (PW)
  ) u_ram (
    .clk    (clk),
    .wr_en  (w_wrEn),
    .wr_addr(w_wrAddr),
    .wr_data(w_wrData),
    .rd_addr(r_ptr),
    .rd_data(w_rdData)
  );

  assign tos    = w_empty ? '0 : w_rdData;
  assign ptr    = r_ptr;
  assign level  = r_level;
  assign empty  = w_empty;
  assign full   = w_full;
  assign stkovf = r_ovf;
  assign stkunf = r_unf;

endmodule

// File: tb/tb_pic_call_stack.sv
// Directed self-checking bench for pic_call_stack: one wrap-mode and one saturate-mode instance share stimulus.
module tb_pic_call_stack;
  import pic_pkg::*;

  logic        clk;
  logic        rst;
  logic        push;
  logic        pop;
  logic [10:0] pushData;
  logic        tosWr;
  logic [10:0] tosWdata;
  logic        clrFlags;

  logic [10:0] wTos, sTos;
  logic [3:0]  wPtr, sPtr;
  logic [4:0]  wLevel, sLevel;
  logic        wEmpty, sEmpty, wFull, sFull, wOvf, sOvf, wUnf, sUnf;
`ifdef PIC_STACK_OVF_RESET_EN
  logic        wRstReq, sRstReq;
`endif

  int checks;
  int errors;

  pic_call_stack #(.WIDTH(11), .DEPTH(16), .SATURATE(STK_WRAP)) u_wrap (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .push_data(pushData),
    .tos_wr(tosWr), .tos_wdata(tosWdata), .clr_flags(clrFlags),
    .tos(wTos), .ptr(wPtr), .level(wLevel), .empty(wEmpty), .full(wFull),
`ifdef PIC_STACK_OVF_RESET_EN
    .stkovf(wOvf), .stkunf(wUnf), .rst_req(wRstReq)
`else
    .stkovf(wOvf), .stkunf(wUnf)
`endif
  );

  pic_call_stack #(.WIDTH(11), .DEPTH(16), .SATURATE(STK_SAT)) u_sat (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .push_data(pushData),
    .tos_wr(tosWr), .tos_wdata(tosWdata), .clr_flags(clrFlags),
    .tos(sTos), .ptr(sPtr), .level(sLevel), .empty(sEmpty), .full(sFull),
`ifdef PIC_STACK_OVF_RESET_EN
    .stkovf(sOvf), .stkunf(sUnf), .rst_req(sRstReq)
`else
    .stkovf(sOvf), .stkunf(sUnf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one cycle of push/pop; outputs are stable #1 after the edge.
  task automatic applyStimulus(input logic pu, input logic po, input logic [10:0] d);
    push     = pu;
    pop      = po;
    pushData = d;
    @(posedge clk);
    #1;
    push     = 1'b0;
    pop      = 1'b0;
  endtask

  task automatic doReset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    doReset();
    checks++;
    if (wPtr !== 4'd15 || wLevel !== 5'd0 || wEmpty !== 1'b1 || wFull !== 1'b0 ||
        wTos !== 11'h000 || wOvf !== 1'b0 || wUnf !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_wrap got ptr=%0d lvl=%0d emp=%b full=%b tos=%h ovf=%b unf=%b want 15 0 1 0 000 0 0",
               wPtr, wLevel, wEmpty, wFull, wTos, wOvf, wUnf);
    end
    checks++;
    if (sPtr !== 4'd15 || sLevel !== 5'd0 || sEmpty !== 1'b1 || sTos !== 11'h000 ||
        sOvf !== 1'b0 || sUnf !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_sat got ptr=%0d lvl=%0d emp=%b tos=%h ovf=%b unf=%b want 15 0 1 000 0 0",
               sPtr, sLevel, sEmpty, sTos, sOvf, sUnf);
    end
  endtask

  task automatic test_push_pop();
    logic [10:0] expTos [4];
    expTos[0] = 11'h103; expTos[1] = 11'h102; expTos[2] = 11'h101; expTos[3] = 11'h000;
    doReset();
    applyStimulus(1'b1, 1'b0, 11'h101);
    applyStimulus(1'b1, 1'b0, 11'h102);
    applyStimulus(1'b1, 1'b0, 11'h103);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (wTos !== expTos[i] || wLevel !== 5'(3 - i)) begin
        errors++;
        $display("[TB] FAIL push_pop step %0d got tos=%h lvl=%0d want tos=%h lvl=%0d",
                 i, wTos, wLevel, expTos[i], 3 - i);
      end
      if (i < 3) applyStimulus(1'b0, 1'b1, 11'h000);
    end
    checks++;
    if (wEmpty !== 1'b1 || wUnf !== 1'b0) begin
      errors++;
      $display("[TB] FAIL push_pop_end got emp=%b unf=%b want 1 0", wEmpty, wUnf);
    end
  endtask

  task automatic test_wrap_overflow();
    doReset();
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 1'b0, 11'(32'h200 + i));
    checks++;
    if (wFull !== 1'b1 || wOvf !== 1'b0) begin
      errors++;
      $display("[TB] FAIL wrap_full got full=%b ovf=%b want 1 0", wFull, wOvf);
    end
    applyStimulus(1'b1, 1'b0, 11'h210);
    checks++;
    if (wOvf !== 1'b1 || wLevel !== 5'd16 || wTos !== 11'h210 || wPtr !== 4'd0) begin
      errors++;
      $display("[TB] FAIL wrap_ovf got ovf=%b lvl=%0d tos=%h ptr=%0d want 1 16 210 0",
               wOvf, wLevel, wTos, wPtr);
    end
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (wTos !== 11'(32'h210 - k)) begin
        errors++;
        $display("[TB] FAIL wrap_pop %0d got tos=%h want %h", k, wTos, 11'(32'h210 - k));
      end
      applyStimulus(1'b0, 1'b1, 11'h000);
    end
    checks++;
    if (wEmpty !== 1'b1 || wTos !== 11'h000 || wUnf !== 1'b0) begin
      errors++;
      $display("[TB] FAIL wrap_drained got emp=%b tos=%h unf=%b want 1 000 0", wEmpty, wTos, wUnf);
    end
  endtask

  task automatic test_saturate();
    doReset();
    for (int i = 0; i < 17; i++) applyStimulus(1'b1, 1'b0, 11'(32'h200 + i));
    checks++;
    if (sTos !== 11'h20F || sOvf !== 1'b1 || sLevel !== 5'd16 || sPtr !== 4'd15) begin
      errors++;
      $display("[TB] FAIL sat_ovf got tos=%h ovf=%b lvl=%0d ptr=%0d want 20f 1 16 15",
               sTos, sOvf, sLevel, sPtr);
    end
    for (int k = 0; k < 16; k++) applyStimulus(1'b0, 1'b1, 11'h000);
    checks++;
    if (sEmpty !== 1'b1 || sUnf !== 1'b0 || sPtr !== 4'd15) begin
      errors++;
      $display("[TB] FAIL sat_drained got emp=%b unf=%b ptr=%0d want 1 0 15", sEmpty, sUnf, sPtr);
    end
    applyStimulus(1'b0, 1'b1, 11'h000);
    checks++;
    if (sUnf !== 1'b1 || sPtr !== 4'd15 || sLevel !== 5'd0) begin
      errors++;
      $display("[TB] FAIL sat_unf got unf=%b ptr=%0d lvl=%0d want 1 15 0", sUnf, sPtr, sLevel);
    end
    checks++;
    if (wUnf !== 1'b1 || wPtr !== 4'd15 || wLevel !== 5'd0) begin
      errors++;
      $display("[TB] FAIL wrap_unf got unf=%b ptr=%0d lvl=%0d want 1 15 0", wUnf, wPtr, wLevel);
    end
  endtask

  task automatic test_push_pop_same();
    doReset();
    applyStimulus(1'b1, 1'b0, 11'h155);
    applyStimulus(1'b1, 1'b1, 11'h2AA);
    checks++;
    if (wTos !== 11'h2AA || wLevel !== 5'd1 || wPtr !== 4'd0 || wOvf !== 1'b0) begin
      errors++;
      $display("[TB] FAIL replace got tos=%h lvl=%0d ptr=%0d ovf=%b want 2aa 1 0 0",
               wTos, wLevel, wPtr, wOvf);
    end
    applyStimulus(1'b0, 1'b1, 11'h000);
    applyStimulus(1'b1, 1'b1, 11'h033);
    checks++;
    if (wTos !== 11'h033 || wLevel !== 5'd1 || wPtr !== 4'd0 || wUnf !== 1'b0) begin
      errors++;
      $display("[TB] FAIL pushpop_empty got tos=%h lvl=%0d ptr=%0d unf=%b want 033 1 0 0",
               wTos, wLevel, wPtr, wUnf);
    end
  endtask

  task automatic test_tos_wr();
    // Continues from one entry (0x033) left by test_push_pop_same.
    tosWr    = 1'b1;
    tosWdata = 11'h3FF;
    applyStimulus(1'b1, 1'b0, 11'h444);
    tosWr    = 1'b0;
    checks++;
    if (wTos !== 11'h3FF || wLevel !== 5'd1 || wPtr !== 4'd0) begin
      errors++;
      $display("[TB] FAIL tos_wr got tos=%h lvl=%0d ptr=%0d want 3ff 1 0", wTos, wLevel, wPtr);
    end
    applyStimulus(1'b0, 1'b1, 11'h000);
    tosWr    = 1'b1;
    tosWdata = 11'h123;
    applyStimulus(1'b0, 1'b1, 11'h000);
    tosWr    = 1'b0;
    checks++;
    if (wTos !== 11'h000 || wLevel !== 5'd0 || wPtr !== 4'd15 || wUnf !== 1'b0) begin
      errors++;
      $display("[TB] FAIL tos_wr_empty got tos=%h lvl=%0d ptr=%0d unf=%b want 000 0 15 0",
               wTos, wLevel, wPtr, wUnf);
    end
  endtask

  task automatic test_flags();
    doReset();
    applyStimulus(1'b0, 1'b1, 11'h000);
`ifdef PIC_STACK_OVF_RESET_EN
    checks++;
    if (wRstReq !== 1'b1 || sRstReq !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rst_req_pulse got w=%b s=%b want 1 1", wRstReq, sRstReq);
    end
`endif
    applyStimulus(1'b0, 1'b0, 11'h000);
    checks++;
    if (wUnf !== 1'b1 || wPtr !== 4'd14) begin
      errors++;
      $display("[TB] FAIL unf_sticky got unf=%b ptr=%0d want 1 14", wUnf, wPtr);
    end
`ifdef PIC_STACK_OVF_RESET_EN
    checks++;
    if (wRstReq !== 1'b0 || sRstReq !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rst_req_one_cycle got w=%b s=%b want 0 0", wRstReq, sRstReq);
    end
`endif
    clrFlags = 1'b1;
    applyStimulus(1'b0, 1'b1, 11'h000);
    checks++;
    if (wUnf !== 1'b1 || sUnf !== 1'b1) begin
      errors++;
      $display("[TB] FAIL set_beats_clr got w=%b s=%b want 1 1", wUnf, sUnf);
    end
`ifdef PIC_STACK_OVF_RESET_EN
    checks++;
    if (wRstReq !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rst_req_retrigger got %b want 1", wRstReq);
    end
`endif
    applyStimulus(1'b0, 1'b0, 11'h000);
    clrFlags = 1'b0;
    checks++;
    if (wUnf !== 1'b0 || sUnf !== 1'b0 || wOvf !== 1'b0) begin
      errors++;
      $display("[TB] FAIL clr_flags got wunf=%b sunf=%b ovf=%b want 0 0 0", wUnf, sUnf, wOvf);
    end
  endtask

  task automatic test_mid_reset();
    doReset();
    applyStimulus(1'b1, 1'b0, 11'h0AA);
    applyStimulus(1'b0, 1'b1, 11'h000);
    applyStimulus(1'b0, 1'b1, 11'h000);
    rst = 1'b1;
    applyStimulus(1'b1, 1'b0, 11'h0BB);
    rst = 1'b0;
    checks++;
    if (wLevel !== 5'd0 || wPtr !== 4'd15 || wUnf !== 1'b0 || wTos !== 11'h000) begin
      errors++;
      $display("[TB] FAIL mid_reset got lvl=%0d ptr=%0d unf=%b tos=%h want 0 15 0 000",
               wLevel, wPtr, wUnf, wTos);
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst      = 1'b1;
    push     = 1'b0;
    pop      = 1'b0;
    pushData = '0;
    tosWr    = 1'b0;
    tosWdata = '0;
    clrFlags = 1'b0;
    test_reset();
    test_push_pop();
    test_wrap_overflow();
    test_saturate();
    test_push_pop_same();
    test_tos_wr();
    test_flags();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
